// File: rtl/dpwm_pkg.sv
// Shared definitions for DPWM-side controllers.
//   - DEFAULT_RESOLUTION / DEFAULT_DIV_WIDTH: default duty and prescaler widths.
//   - state_t: 3-bit soft-start sequencer state encoding.
package dpwm_pkg;

  localparam int DEFAULT_RESOLUTION = 12;
  localparam int DEFAULT_DIV_WIDTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

endpackage

// File: rtl/dpwm_period_timer.sv
// PWM period timer mirroring the DPWM fs semantics.
// The counter reloads fs after reaching all-ones, so one period is
// 2^RESOLUTION - fs clocks; fs = all-ones yields a tick every clock.
// A new fs is only picked up on the reload, i.e. at the next wrap.
// Ports:
//   hf_clock    : clock shared with the DPWM
//   reset       : asynchronous, active-low
//   fs          : period setting (same value fed to the DPWM)
//   period_tick : high for one clock at the end of each PWM period
module dpwm_period_timer
  import dpwm_pkg::*;
#(
  parameter int RESOLUTION = DEFAULT_RESOLUTION
) (
  input  logic                  hf_clock,
  input  logic                  reset,
  input  logic [RESOLUTION-1:0] fs,
  output logic                  period_tick
);

  localparam logic [RESOLUTION-1:0] ALL_ONES = '1;

  logic [RESOLUTION-1:0] cnt_p0;

  assign period_tick = (cnt_p0 == ALL_ONES);

  always_ff @(posedge hf_clock or negedge reset) begin
    if (!reset) begin
      cnt_p0 <= '0;
    end else if (period_tick) begin
      cnt_p0 <= fs;
    end else begin
      cnt_p0 <= cnt_p0 + RESOLUTION'(1);
    end
  end

endmodule

// File: rtl/dpwm_softstart_ctrl.sv
// Soft-start / soft-stop sequencer in front of a DPWM instance.
// Ramps duty from 0 up to a latched target, holds it, ramps back to 0,
// and forces an immediate shutdown on fault. Duty only moves on ramp
// update ticks, which are derived from PWM period boundaries.
// Ports:
//   hf_clock, reset          : DPWM clock, async active-low reset
//   start / stop             : pulses to begin ramp-up / ramp-down
//   fault                    : level, forces FAULT (highest priority)
//   fault_clear              : pulse, leaves FAULT once fault is low
//   target_duty              : run duty, latched when start is accepted
//   ramp_step                : duty change per update (0 acts as 1)
//   ramp_div                 : one update every ramp_div+1 PWM periods
//   fs                       : DPWM period setting
//   duty_cycle, enable       : registered drives to the DPWM
//   state, faulted           : registered status
module dpwm_softstart_ctrl
  import dpwm_pkg::*;
#(
  parameter int RESOLUTION = DEFAULT_RESOLUTION,
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input  logic                  hf_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  fault,
  input  logic                  fault_clear,
  input  logic [RESOLUTION-1:0] target_duty,
  input  logic [RESOLUTION-1:0] ramp_step,
  input  logic [DIV_WIDTH-1:0]  ramp_div,
  input  logic [RESOLUTION-1:0] fs,
  output logic [RESOLUTION-1:0] duty_cycle,
  output logic                  enable,
  output logic [2:0]            state,
  output logic                  faulted
);

  // Saturating ramp arithmetic. The add is done one bit wider so a large
  // step never wraps before the clamp to the target.
  function automatic logic [RESOLUTION-1:0] sat_add_clamp(
    input logic [RESOLUTION-1:0] a,
    input logic [RESOLUTION-1:0] b,
    input logic [RESOLUTION-1:0] lim
  );
    logic [RESOLUTION:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) return lim;
    else                   return sum[RESOLUTION-1:0];
  endfunction

  function automatic logic [RESOLUTION-1:0] sat_sub_floor(
    input logic [RESOLUTION-1:0] a,
    input logic [RESOLUTION-1:0] b
  );
    logic signed [RESOLUTION+1:0] diff;
    diff = $signed({2'b00, a}) - $signed({2'b00, b});
    if (diff < 0) return '0;
    else          return diff[RESOLUTION-1:0];
  endfunction

  state_t                state_q;
  logic [RESOLUTION-1:0] duty_q;
  logic [RESOLUTION-1:0] target_q;
  logic [DIV_WIDTH-1:0]  presc_q;
  logic                  enable_q;
  logic                  faulted_q;

  logic                  period_tick;
  logic                  upd_tick;
  logic [RESOLUTION-1:0] step_eff;
  logic [RESOLUTION-1:0] duty_up;
  logic [RESOLUTION-1:0] duty_dn;

  dpwm_period_timer #(
    .RESOLUTION (RESOLUTION)
  ) u_period_timer (
    .hf_clock    (hf_clock),
    .reset       (reset),
    .fs          (fs),
    .period_tick (period_tick)
  );

  assign step_eff = (ramp_step == '0) ? RESOLUTION'(1) : ramp_step;
  assign upd_tick = period_tick && (presc_q == ramp_div);
  assign duty_up  = sat_add_clamp(duty_q, step_eff, target_q);
  assign duty_dn  = sat_sub_floor(duty_q, step_eff);

  always_ff @(posedge hf_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      duty_q    <= '0;
      target_q  <= '0;
      presc_q   <= '0;
      enable_q  <= 1'b0;
      faulted_q <= 1'b0;
    end else begin
      // Prescaler counts PWM periods; the >= also recovers if ramp_div is
      // lowered below the running count. Ramp entries below override it.
      if (period_tick) begin
        presc_q <= (presc_q >= ramp_div) ? '0 : presc_q + DIV_WIDTH'(1);
      end

      if (fault) begin
        state_q   <= ST_FAULT;
        duty_q    <= '0;
        enable_q  <= 1'b0;
        faulted_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !stop) begin
              target_q <= target_duty;
              presc_q  <= '0;
              enable_q <= 1'b1;
              state_q  <= ST_RAMP_UP;
            end
          end

          // Transitions take precedence over a coincident update tick.
          ST_RAMP_UP: begin
            if (stop) begin
              presc_q <= '0;
              state_q <= ST_RAMP_DOWN;
            end else if (duty_q == target_q) begin
              state_q <= ST_RUN;
            end else if (upd_tick) begin
              duty_q <= duty_up;
            end
          end

          ST_RUN: begin
            if (stop) begin
              presc_q <= '0;
              state_q <= ST_RAMP_DOWN;
            end
          end

          // Reaching zero on an update leaves immediately, so enable falls
          // on the same edge as the final duty step.
          ST_RAMP_DOWN: begin
            if (start && !stop) begin
              target_q <= target_duty;
              presc_q  <= '0;
              state_q  <= ST_RAMP_UP;
            end else if (duty_q == '0) begin
              enable_q <= 1'b0;
              state_q  <= ST_IDLE;
            end else if (upd_tick) begin
              duty_q <= duty_dn;
              if (duty_dn == '0) begin
                enable_q <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end
          end

          ST_FAULT: begin
            if (fault_clear) begin
              faulted_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end

          default: begin
            duty_q    <= '0;
            enable_q  <= 1'b0;
            faulted_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign duty_cycle = duty_q;
  assign enable     = enable_q;
  assign state      = state_q;
  assign faulted    = faulted_q;

endmodule

// File: tb/tb_dpwm_softstart_ctrl.sv
module tb_dpwm_softstart_ctrl;

  logic        hf_clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        fault;
  logic        fault_clear;
  logic [11:0] target_duty;
  logic [11:0] ramp_step;
  logic [7:0]  ramp_div;
  logic [11:0] fs;
  logic [11:0] duty_cycle;
  logic        enable;
  logic [2:0]  state;
  logic        faulted;

  int total  = 0;
  int passed = 0;

  always #5 hf_clock = ~hf_clock;

  dpwm_softstart_ctrl #(
    .RESOLUTION (12),
    .DIV_WIDTH  (8)
  ) dut (
    .hf_clock    (hf_clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .fault       (fault),
    .fault_clear (fault_clear),
    .target_duty (target_duty),
    .ramp_step   (ramp_step),
    .ramp_div    (ramp_div),
    .fs          (fs),
    .duty_cycle  (duty_cycle),
    .enable      (enable),
    .state       (state),
    .faulted     (faulted)
  );

  task automatic tick();
    @(posedge hf_clock);
    #1;
  endtask

  // Advance until duty_cycle differs from prev, bounded by budget clocks.
  task automatic wait_change(input logic [11:0] prev, input int budget,
                             output logic [11:0] val, output int cycles,
                             output bit timed_out);
    cycles    = 0;
    timed_out = 1'b1;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (duty_cycle !== prev) begin
        timed_out = 1'b0;
        break;
      end
    end
    val = duty_cycle;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (2) tick();
    total++; if (duty_cycle !== 12'd0) $display("FAIL rst_duty: got %0d want 0", duty_cycle); else passed++;
    total++; if (enable !== 1'b0) $display("FAIL rst_enable: got %0b want 0", enable); else passed++;
    total++; if (state !== 3'd0) $display("FAIL rst_state: got %0d want 0", state); else passed++;
    total++; if (faulted !== 1'b0) $display("FAIL rst_faulted: got %0b want 0", faulted); else passed++;
    reset = 1'b1;
    tick();
    total++; if (state !== 3'd0) $display("FAIL rst_release_state: got %0d want 0", state); else passed++;
  endtask

  // fs=4088 -> 8-clock period; step 100 towards 250.
  task automatic test_ramp_up();
    logic [11:0] v;
    int cyc;
    bit to;
    fs = 12'd4088; ramp_div = 8'd0; ramp_step = 12'd100; target_duty = 12'd250;
    pulse_start();
    total++; if (state !== 3'd1) $display("FAIL up_state: got %0d want 1", state); else passed++;
    total++; if (enable !== 1'b1) $display("FAIL up_enable: got %0b want 1", enable); else passed++;
    wait_change(12'd0, 5000, v, cyc, to);
    total++; if (to || v !== 12'd100) $display("FAIL up_duty1: got %0d want 100 timeout %0b", v, to); else passed++;
    wait_change(v, 50, v, cyc, to);
    total++; if (to || v !== 12'd200) $display("FAIL up_duty2: got %0d want 200 timeout %0b", v, to); else passed++;
    total++; if (cyc !== 8) $display("FAIL up_interval: got %0d want 8", cyc); else passed++;
    wait_change(v, 50, v, cyc, to);
    total++; if (to || v !== 12'd250) $display("FAIL up_duty3: got %0d want 250 timeout %0b", v, to); else passed++;
    total++; if (state !== 3'd1) $display("FAIL up_state_at_target: got %0d want 1", state); else passed++;
    tick();
    total++; if (state !== 3'd2) $display("FAIL run_state: got %0d want 2", state); else passed++;
    total++; if (enable !== 1'b1) $display("FAIL run_enable: got %0b want 1", enable); else passed++;
    // Target changes and start are ignored in RUN.
    target_duty = 12'd999;
    pulse_start();
    repeat (20) tick();
    total++; if (duty_cycle !== 12'd250) $display("FAIL run_hold_duty: got %0d want 250", duty_cycle); else passed++;
    total++; if (state !== 3'd2) $display("FAIL run_hold_state: got %0d want 2", state); else passed++;
    target_duty = 12'd250;
  endtask

  task automatic test_ramp_down();
    logic [11:0] v;
    int cyc;
    bit to;
    pulse_stop();
    total++; if (state !== 3'd3) $display("FAIL dn_state: got %0d want 3", state); else passed++;
    wait_change(12'd250, 50, v, cyc, to);
    total++; if (to || v !== 12'd150) $display("FAIL dn_duty1: got %0d want 150 timeout %0b", v, to); else passed++;
    wait_change(v, 50, v, cyc, to);
    total++; if (to || v !== 12'd50) $display("FAIL dn_duty2: got %0d want 50 timeout %0b", v, to); else passed++;
    total++; if (cyc !== 8) $display("FAIL dn_interval: got %0d want 8", cyc); else passed++;
    total++; if (enable !== 1'b1) $display("FAIL dn_enable_mid: got %0b want 1", enable); else passed++;
    wait_change(v, 50, v, cyc, to);
    total++; if (to || v !== 12'd0) $display("FAIL dn_duty3: got %0d want 0 timeout %0b", v, to); else passed++;
    total++; if (state !== 3'd0) $display("FAIL dn_idle_state: got %0d want 0", state); else passed++;
    total++; if (enable !== 1'b0) $display("FAIL dn_idle_enable: got %0b want 0", enable); else passed++;
  endtask

  task automatic test_fault();
    logic [11:0] v;
    int cyc;
    bit to;
    pulse_start();
    wait_change(12'd0, 50, v, cyc, to);
    wait_change(v, 50, v, cyc, to);
    total++; if (to || v !== 12'd200) $display("FAIL flt_pre_duty: got %0d want 200 timeout %0b", v, to); else passed++;
    fault = 1'b1;
    tick();
    total++; if (enable !== 1'b0) $display("FAIL flt_enable: got %0b want 0", enable); else passed++;
    total++; if (duty_cycle !== 12'd0) $display("FAIL flt_duty: got %0d want 0", duty_cycle); else passed++;
    total++; if (faulted !== 1'b1) $display("FAIL flt_faulted: got %0b want 1", faulted); else passed++;
    total++; if (state !== 3'd4) $display("FAIL flt_state: got %0d want 4", state); else passed++;
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    total++; if (state !== 3'd4) $display("FAIL flt_clear_ignored: got %0d want 4", state); else passed++;
    total++; if (faulted !== 1'b1) $display("FAIL flt_clear_ignored_flag: got %0b want 1", faulted); else passed++;
    fault = 1'b0;
    tick();
    total++; if (state !== 3'd4) $display("FAIL flt_stays: got %0d want 4", state); else passed++;
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    total++; if (state !== 3'd0) $display("FAIL flt_exit_state: got %0d want 0", state); else passed++;
    total++; if (faulted !== 1'b0) $display("FAIL flt_exit_flag: got %0b want 0", faulted); else passed++;
    total++; if (enable !== 1'b0) $display("FAIL flt_exit_enable: got %0b want 0", enable); else passed++;
  endtask

  // Step 0 acts as 1; ramp_div=2 -> one update per 3 periods (24 clocks).
  task automatic test_step_zero();
    logic [11:0] v;
    int cyc;
    bit to;
    int n;
    ramp_step = 12'd0; ramp_div = 8'd2; target_duty = 12'd3;
    pulse_start();
    wait_change(12'd0, 100, v, cyc, to);
    total++; if (to || v !== 12'd1) $display("FAIL sz_duty1: got %0d want 1 timeout %0b", v, to); else passed++;
    wait_change(v, 100, v, cyc, to);
    total++; if (to || v !== 12'd2) $display("FAIL sz_duty2: got %0d want 2 timeout %0b", v, to); else passed++;
    total++; if (cyc !== 24) $display("FAIL sz_interval: got %0d want 24", cyc); else passed++;
    wait_change(v, 100, v, cyc, to);
    total++; if (to || v !== 12'd3) $display("FAIL sz_duty3: got %0d want 3 timeout %0b", v, to); else passed++;
    tick();
    total++; if (state !== 3'd2) $display("FAIL sz_run: got %0d want 2", state); else passed++;
    pulse_stop();
    n = 0;
    while (state !== 3'd0 && n < 300) begin
      tick();
      n++;
    end
    total++; if (state !== 3'd0 || duty_cycle !== 12'd0) $display("FAIL sz_back_idle: got state %0d duty %0d want 0 0", state, duty_cycle); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] v;
    int cyc;
    bit to;
    ramp_step = 12'd100; ramp_div = 8'd0; target_duty = 12'd250;
    pulse_start();
    wait_change(12'd0, 50, v, cyc, to);
    total++; if (to || v !== 12'd100) $display("FAIL b2b_duty1: got %0d want 100 timeout %0b", v, to); else passed++;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++; if (state !== 3'd3) $display("FAIL b2b_stop_wins: got %0d want 3", state); else passed++;
    total++; if (duty_cycle !== 12'd100) $display("FAIL b2b_duty_held: got %0d want 100", duty_cycle); else passed++;
    ramp_step = 12'd50;
    wait_change(12'd100, 50, v, cyc, to);
    total++; if (to || v !== 12'd50) $display("FAIL b2b_down50: got %0d want 50 timeout %0b", v, to); else passed++;
    ramp_step = 12'd100;
    pulse_start();
    total++; if (state !== 3'd1) $display("FAIL b2b_resume_state: got %0d want 1", state); else passed++;
    total++; if (duty_cycle !== 12'd50) $display("FAIL b2b_resume_duty: got %0d want 50", duty_cycle); else passed++;
    wait_change(12'd50, 50, v, cyc, to);
    total++; if (to || v !== 12'd150) $display("FAIL b2b_up150: got %0d want 150 timeout %0b", v, to); else passed++;
    wait_change(v, 50, v, cyc, to);
    total++; if (to || v !== 12'd250) $display("FAIL b2b_up250: got %0d want 250 timeout %0b", v, to); else passed++;
    tick();
    total++; if (state !== 3'd2) $display("FAIL b2b_run: got %0d want 2", state); else passed++;
  endtask

  // Reset dropped between edges while in RUN must clear outputs at once.
  task automatic test_async_reset();
    @(posedge hf_clock);
    #3;
    reset = 1'b0;
    #1;
    total++; if (enable !== 1'b0) $display("FAIL ar_enable: got %0b want 0", enable); else passed++;
    total++; if (duty_cycle !== 12'd0) $display("FAIL ar_duty: got %0d want 0", duty_cycle); else passed++;
    total++; if (state !== 3'd0) $display("FAIL ar_state: got %0d want 0", state); else passed++;
    #2;
    reset = 1'b1;
    tick();
    total++; if (state !== 3'd0 || enable !== 1'b0) $display("FAIL ar_release: got state %0d enable %0b want 0 0", state, enable); else passed++;
  endtask

  initial begin
    start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clear = 1'b0;
    target_duty = 12'd0; ramp_step = 12'd0; ramp_div = 8'd0; fs = 12'd4088;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_fault();
    test_step_zero();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
